sobel_window_gen: RTL and testbench
===================================

SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, 640: pixels per line; minimum 3.
REQ-002 SHALL have parameter IMG_H, 480: lines per frame; minimum 3.
REQ-003 SHALL have parameter PIX_W, 8: bits per grayscale pixel.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  upstream pixel present.
REQ-007 SHALL have port in_ready  output  1  block can accept a pixel this cycle.
REQ-008 SHALL have port in_pixel  input  PIX_W  raster-order pixel.
REQ-009 SHALL have port in_sof  input  1  marks the beat carrying pixel (0,0) of a frame.
REQ-010 SHALL have port out_valid  output  1  3x3 window present for the Sobel convolution stage.
REQ-011 SHALL have port out_ready  input  1  Sobel stage accepts the window.
REQ-012 SHALL have port out_win  output  9*PIX_W  window w[r][c], slot index 3r+c, slot 0 (top-left) in the LSBs.
REQ-013 SHALL have port out_eof  output  1  qualifies the last window of a frame.

Function
REQ-014 SHALL accept a beat only when in_valid and in_ready are both 1; bubbles SHALL change no state.
REQ-015 SHALL drive in_ready = !out_valid || out_ready (combinational).
REQ-016 SHALL track col (0..IMG_W-1) and row (0..IMG_H-1) of the accepted pixel: col increments per beat; col wraps to 0 and row increments after IMG_W-1; both return to 0 after (IMG_H-1, IMG_W-1).
REQ-017 SHALL treat an accepted beat with in_sof=1 as (0,0), regardless of counter state.
REQ-018 SHALL keep two line buffers of IMG_W x PIX_W: on accept at col c, read lb0[c] (row-2) and lb1[c] (row-1) before writing, then write lb0[c]<=lb1[c] and lb1[c]<=in_pixel.
REQ-019 SHALL, on accept, shift the 3x3 window registers one column left and load the right column {lb0[c], lb1[c], in_pixel} as rows 0,1,2.
REQ-020 SHALL, one cycle after accepting a pixel with row>=2 and col>=2, set out_valid=1 with out_win centred on (row-1, col-1); no window is produced for any other pixel.
REQ-021 SHALL set out_eof=1 with the window produced by pixel (IMG_H-1, IMG_W-1), else 0.
REQ-022 SHALL hold out_win, out_eof and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL clear out_valid after the handshake unless a new window is loaded in the same cycle (back-to-back throughput of one window per clock).
REQ-024 SHALL never drop or duplicate a pixel or a window under any in_valid/out_ready pattern.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, set col=0, row=0, window registers=0, out_valid=0, out_win=0, out_eof=0.
REQ-026 SHALL leave line-buffer contents unreset; stale data SHALL never reach out_win because rows 0-1 produce no window.
REQ-027 SHALL, on reset mid-frame, discard the partial frame; the next accepted beat is (0,0).

Structure
REQ-028 SHALL take PIX_W default and the window slot-index constants (W00..W22) from shared package sobel_pkg, used also by the Sobel convolution stage.
REQ-029 SHALL implement each line buffer as sub-module sobel_line_buffer (IMG_W x PIX_W, one read-before-write port, no reset), instantiated twice.

Verification (IMG_W=4, IMG_H=4, pixel=16*row+col)
REQ-030 SHALL cover: 16 beats, out_ready=1 -> exactly 4 windows, first one cycle after pixel 0x22, out_win slots 0..8 = 00,01,02,10,11,12,20,21,22; out_eof only on 4th window (centre 0x22).
REQ-031 SHALL cover: out_ready=0 after first window -> in_ready=0, out_win stable 5 cycles; release -> remaining 3 windows correct, none lost.
REQ-032 SHALL cover: line wrap pixel 0x23 -> 0x30 -> no window for 0x30, 0x31; next window after 0x32 centred 0x21.
REQ-033 SHALL cover: in_sof=1 on 6th beat -> counters resync; next window only after 11 further beats, centred (1,1) of new frame.
REQ-034 SHALL cover: rst_n=0 one cycle with out_valid=1 -> out_valid=0 next cycle; subsequent beat treated as (0,0).
REQ-035 SHALL cover: random in_valid gaps and random out_ready -> window sequence identical to REQ-030.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel pipeline.
// Holds the default pixel width and the 3x3 window slot indices. The window
// generator and the Sobel convolution stage both import these.
package sobel_pkg;

    localparam int unsigned PIX_W_DEFAULT = 8;
    localparam int unsigned WIN_N         = 9;

    // Slot index 3*row + col; slot 0 (top-left) sits in the LSBs of a window bus.
    localparam int unsigned W00 = 0;
    localparam int unsigned W01 = 1;
    localparam int unsigned W02 = 2;
    localparam int unsigned W10 = 3;
    localparam int unsigned W11 = 4;
    localparam int unsigned W12 = 5;
    localparam int unsigned W20 = 6;
    localparam int unsigned W21 = 7;
    localparam int unsigned W22 = 8;

endpackage

// File: rtl/sobel_window_gen_if.sv
// Stream interface for the window generator.
// Carries the pixel stream (in_*) and the window stream (out_*).
// The slave modport is the generator's view. The master modport is the
// view of the environment that feeds pixels and takes windows.
interface sobel_window_gen_if
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEFAULT
);

    logic                     in_valid;
    logic                     in_ready;
    logic [PIX_W-1:0]         in_pixel;
    logic                     in_sof;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIN_N*PIX_W-1:0]   out_win;
    logic                     out_eof;

    modport slave (
        input  in_valid, in_pixel, in_sof, out_ready,
        output in_ready, out_valid, out_win, out_eof
    );

    modport master (
        output in_valid, in_pixel, in_sof, out_ready,
        input  in_ready, out_valid, out_win, out_eof
    );

endinterface

// File: rtl/sobel_line_buffer.sv
// One-line pixel store with a single read-before-write port.
//   clk     : write clock
//   wr_en   : write wr_data at addr on the rising edge
//   addr    : shared read/write address
//   wr_data : pixel to store
//   rd_data : current contents at addr, combinational, so it shows the old value
// The memory is not reset.
module sobel_line_buffer #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned PIX_W = 8
) (
    input  logic                              clk,
    input  logic                              wr_en,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] addr,
    input  logic [PIX_W-1:0]                  wr_data,
    output logic [PIX_W-1:0]                  rd_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Builds 3x3 pixel windows from a raster pixel stream for the Sobel stage.
//   clk, rst_n : clock and synchronous active-low reset
//   io (slave) : in_valid/in_ready/in_pixel/in_sof    pixel stream
//                out_valid/out_ready/out_win/out_eof  window stream
// A window is issued one cycle after a pixel at row>=2, col>=2 is accepted.
// That window is centred on (row-1, col-1).
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned PIX_W = PIX_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    sobel_window_gen_if.slave io
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned WIN_W = WIN_N * PIX_W;

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [WIN_W-1:0] win_q;
    logic             out_valid_q;
    logic             out_eof_q;

    logic             in_ready_c;
    logic             accept_c;
    logic [COL_W-1:0] cur_col_c;
    logic [ROW_W-1:0] cur_row_c;
    logic             last_col_c;
    logic             last_row_c;
    logic             win_hit_c;
    logic             eof_hit_c;
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;

    // Only accept a pixel when the output slot is free or is emptying this cycle.
    assign in_ready_c   = !out_valid_q || io.out_ready;
    assign accept_c     = io.in_valid && in_ready_c;
    assign io.in_ready  = in_ready_c;
    assign io.out_valid = out_valid_q;
    assign io.out_win   = win_q;
    assign io.out_eof   = out_eof_q;

    // Position of the pixel on the bus; start-of-frame forces (0,0).
    always_comb begin
        cur_col_c  = io.in_sof ? '0 : col_q;
        cur_row_c  = io.in_sof ? '0 : row_q;
        last_col_c = (cur_col_c == COL_W'(IMG_W - 1));
        last_row_c = (cur_row_c == ROW_W'(IMG_H - 1));
        win_hit_c  = (cur_row_c >= ROW_W'(2)) && (cur_col_c >= COL_W'(2));
        eof_hit_c  = last_row_c && last_col_c;
    end

    // lb0 holds row-2, lb1 holds row-1. Each accept ages lb1 into lb0.
    sobel_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb0 (
        .clk     (clk),
        .wr_en   (accept_c),
        .addr    (cur_col_c),
        .wr_data (lb1_rd),
        .rd_data (lb0_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb1 (
        .clk     (clk),
        .wr_en   (accept_c),
        .addr    (cur_col_c),
        .wr_data (io.in_pixel),
        .rd_data (lb1_rd)
    );

    // Raster counters, window shift register and the output slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
        end else if (accept_c) begin
            col_q <= last_col_c ? '0 : cur_col_c + COL_W'(1);
            if (last_col_c) begin
                row_q <= last_row_c ? '0 : cur_row_c + ROW_W'(1);
            end else begin
                row_q <= cur_row_c;
            end
            win_q[W00*PIX_W +: PIX_W] <= win_q[W01*PIX_W +: PIX_W];
            win_q[W01*PIX_W +: PIX_W] <= win_q[W02*PIX_W +: PIX_W];
            win_q[W02*PIX_W +: PIX_W] <= lb0_rd;
            win_q[W10*PIX_W +: PIX_W] <= win_q[W11*PIX_W +: PIX_W];
            win_q[W11*PIX_W +: PIX_W] <= win_q[W12*PIX_W +: PIX_W];
            win_q[W12*PIX_W +: PIX_W] <= lb1_rd;
            win_q[W20*PIX_W +: PIX_W] <= win_q[W21*PIX_W +: PIX_W];
            win_q[W21*PIX_W +: PIX_W] <= win_q[W22*PIX_W +: PIX_W];
            win_q[W22*PIX_W +: PIX_W] <= io.in_pixel;
            out_valid_q <= win_hit_c;
            out_eof_q   <= win_hit_c && eof_hit_c;
        end else if (io.out_ready) begin
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 image.
// Each pixel value is 16*row + col.
module tb_sobel_window_gen;

    localparam int unsigned PW = 8;
    localparam int unsigned WW = 9 * PW;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   pix_i;
    int   win_i;
    int   cyc;
    bit   acc;

    sobel_window_gen_if #(.PIX_W(PW)) io ();

    sobel_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pix_of(input int r, input int c);
        return PW'(16 * r + c);
    endfunction

    // Window centred on (r,c): slot 3i+j holds the pixel at (r-1+i, c-1+j).
    function automatic logic [WW-1:0] exp_win(input int r, input int c);
        logic [WW-1:0] v;
        v = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[(3*i+j)*PW +: PW] = pix_of(r - 1 + i, c - 1 + j);
        return v;
    endfunction

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic chk_win(input string tag, input int r, input int c, input bit eof);
        check({tag, "_valid"}, WW'(io.out_valid), WW'(1));
        check({tag, "_win"}, io.out_win, exp_win(r, c));
        check({tag, "_eof"}, WW'(io.out_eof), WW'(eof));
    endtask

    task automatic chk_none(input string tag);
        check({tag, "_novalid"}, WW'(io.out_valid), WW'(0));
    endtask

    // One accepted beat with out_ready held high.
    task automatic beat(input logic [PW-1:0] pix, input bit sof);
        io.in_valid = 1'b1;
        io.in_pixel = pix;
        io.in_sof   = sof;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.in_sof   = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.in_pixel  = '0;
        io.in_sof    = 1'b0;
        io.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", WW'(io.out_valid), WW'(0));
        check("rst_win", io.out_win, WW'(0));
        check("rst_eof", WW'(io.out_eof), WW'(0));
        check("rst_in_ready", WW'(io.in_ready), WW'(1));
        rst_n = 1'b1;

        // Full frame, out_ready=1: windows after 0x22, 0x23, 0x32 and 0x33 only.
        // The row-2 to row-3 wrap gives no window for 0x30 or 0x31.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                beat(pix_of(r, c), (r == 0 && c == 0));
                if (r >= 2 && c >= 2) chk_win("frame", r - 1, c - 1, (r == 3 && c == 3));
                else chk_none("frame");
            end
        end

        // Stall the first window for 5 cycles, then release it.
        for (int k = 0; k < 11; k++) beat(pix_of(k / 4, k % 4), (k == 0));
        chk_win("stall_first", 1, 1, 1'b0);
        io.out_ready = 1'b0;
        io.in_valid  = 1'b1;
        io.in_pixel  = pix_of(2, 3);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("stall_in_ready", WW'(io.in_ready), WW'(0));
            check("stall_valid", WW'(io.out_valid), WW'(1));
            check("stall_win", io.out_win, exp_win(1, 1));
        end
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        chk_win("stall_w2", 1, 2, 1'b0);
        beat(pix_of(3, 0), 1'b0);
        chk_none("stall_r3c0");
        beat(pix_of(3, 1), 1'b0);
        chk_none("stall_r3c1");
        beat(pix_of(3, 2), 1'b0);
        chk_win("stall_w3", 2, 1, 1'b0);
        beat(pix_of(3, 3), 1'b0);
        chk_win("stall_w4", 2, 2, 1'b1);

        // A new start-of-frame on the 6th beat resyncs the counters.
        for (int k = 0; k < 5; k++) beat(PW'(8'he0 + k), (k == 0));
        for (int k = 0; k < 11; k++) begin
            beat(pix_of(k / 4, k % 4), (k == 0));
            if (k == 10) chk_win("sof_win", 1, 1, 1'b0);
            else chk_none("sof_gap");
        end

        // Reset while a window is pending; the next beat is (0,0) without sof.
        for (int k = 0; k < 11; k++) beat(pix_of(k / 4, k % 4), (k == 0));
        chk_win("prerst", 1, 1, 1'b0);
        io.out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("prerst_hold", WW'(io.out_valid), WW'(1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_valid", WW'(io.out_valid), WW'(0));
        check("midrst_win", io.out_win, WW'(0));
        check("midrst_eof", WW'(io.out_eof), WW'(0));
        io.out_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            beat(pix_of(k / 4, k % 4), 1'b0);
            if (k == 10) chk_win("postrst_win", 1, 1, 1'b0);
            else chk_none("postrst_gap");
        end
        @(posedge clk);
        #1;
        chk_none("postrst_drain");

        // Random input gaps and random out_ready; the window sequence must match the full-frame case.
        pix_i = 0;
        win_i = 0;
        cyc   = 0;
        while ((pix_i < 16 || win_i < 4) && cyc < 400) begin
            io.in_valid  = (pix_i < 16) && ($urandom_range(0, 2) != 0);
            io.in_pixel  = pix_of(pix_i / 4, pix_i % 4);
            io.in_sof    = (pix_i == 0);
            io.out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = io.in_valid && io.in_ready;
            if (io.out_valid && io.out_ready) begin
                if (win_i < 4) chk_win("rand", 1 + win_i / 2, 1 + win_i % 2, (win_i == 3));
                win_i++;
            end
            @(posedge clk);
            #1;
            if (acc) pix_i++;
            cyc++;
        end
        io.in_valid  = 1'b0;
        io.in_sof    = 1'b0;
        io.out_ready = 1'b1;
        check("rand_budget", WW'(cyc < 400), WW'(1));
        check("rand_count", WW'(win_i), WW'(4));
        repeat (3) @(posedge clk);
        #1;
        chk_none("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
